// File: rtl/shift_seq_if.sv
// Purpose: bundles the shift_seq request inputs and result outputs.
// Latency: none (wires only); the sequencer defines all timing.
// Backpressure: none; start is only honoured while the sequencer is idle.
// Ports: start/op/count/ar_in/arx_in (request), busy/done/ar_out/arx_out/step_amt (status/result).
interface shift_seq_if #(
    parameter int W = 36
);
    logic         start;
    logic [1:0]   op;
    logic [8:0]   count;
    logic [W-1:0] ar_in;
    logic [W-1:0] arx_in;
    logic         busy;
    logic         done;
    logic [W-1:0] ar_out;
    logic [W-1:0] arx_out;
    logic [5:0]   step_amt;

    // master issues shift requests, slave is the sequencer
    modport master (
        output start, op, count, ar_in, arx_in,
        input  busy, done, ar_out, arx_out, step_amt
    );
    modport slave (
        input  start, op, count, ar_in, arx_in,
        output busy, done, ar_out, arx_out, step_amt
    );
endinterface

// File: rtl/shift_seq.sv
// Purpose: splits an LSH/ROT/LSHC/ROTC count of -256..+255 into passes of at most MAXSTEP bits.
// Latency: ceil(|count|/MAXSTEP) SHIFT cycles, then a one-cycle done pulse; count=0 gives done at T+1.
// Backpressure: start is accepted only in IDLE; start while busy or during done is dropped.
// Ports: clk, CROBAR (sync active-high reset), bus (shift_seq_if.slave).
module shift_seq #(
    parameter int W       = 36,
    parameter int MAXSTEP = 35
) (
    input  logic         clk,
    input  logic         CROBAR,
    shift_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LSH  = 2'b00;
    localparam logic [1:0] OP_ROT  = 2'b01;
    localparam logic [1:0] OP_LSHC = 2'b10;
    localparam logic [1:0] OP_ROTC = 2'b11;

    state_t       state_q, state_d;
    logic [1:0]   op_q, op_d;
    logic         dir_q, dir_d;      // 1 = right (negative count)
    logic [9:0]   rem_q, rem_d;      // 10 bits so that |-256| fits
    logic [W-1:0] ar_q, ar_d;
    logic [W-1:0] arx_q, arx_d;

    // Magnitude of the signed request count, sign-extended to 10 bits first
    // so -256 negates to 256 instead of wrapping.
    logic [9:0] cnt_ext;
    logic [9:0] cnt_mag;
    assign cnt_ext = {bus.count[8], bus.count};
    assign cnt_mag = bus.count[8] ? (~cnt_ext + 10'd1) : cnt_ext;

    // Amount applied this pass.
    logic [5:0] pass_amt;
    assign pass_amt = (rem_q > 10'(MAXSTEP)) ? 6'(MAXSTEP) : rem_q[5:0];

    // Complement amounts for the rotate wrap-around terms.
    logic [6:0] inv_w;
    logic [7:0] inv_2w;
    assign inv_w  = 7'(W) - {1'b0, pass_amt};
    assign inv_2w = 8'(2 * W) - {2'b00, pass_amt};

    // Single-pass shifter. Vector MSB is PDP-10 bit 0, so "left" is <<.
    // AR LSB (bit 35) abuts ARX MSB (bit 0) in the 72-bit pair.
    logic [2*W-1:0] pair;
    logic [W-1:0]   lsh_res, rot_res;
    logic [2*W-1:0] lshc_res, rotc_res;
    assign pair = {ar_q, arx_q};

    always_comb begin
        if (dir_q) begin
            lsh_res  = ar_q >> pass_amt;
            rot_res  = (ar_q >> pass_amt) | (ar_q << inv_w);
            lshc_res = pair >> pass_amt;
            rotc_res = (pair >> pass_amt) | (pair << inv_2w);
        end else begin
            lsh_res  = ar_q << pass_amt;
            rot_res  = (ar_q << pass_amt) | (ar_q >> inv_w);
            lshc_res = pair << pass_amt;
            rotc_res = (pair << pass_amt) | (pair >> inv_2w);
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        ar_d    = ar_q;
        arx_d   = arx_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    dir_d   = bus.count[8];
                    rem_d   = cnt_mag;
                    ar_d    = bus.ar_in;
                    arx_d   = bus.arx_in;
                    state_d = (cnt_mag != 10'd0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                rem_d = rem_q - {4'b0000, pass_amt};
                case (op_q)
                    OP_LSH:  ar_d = lsh_res;
                    OP_ROT:  ar_d = rot_res;
                    OP_LSHC: {ar_d, arx_d} = lshc_res;
                    OP_ROTC: {ar_d, arx_d} = rotc_res;
                    default: ar_d = ar_q;
                endcase
                if (rem_d == 10'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            dir_q   <= 1'b0;
            rem_q   <= 10'd0;
            ar_q    <= '0;
            arx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            ar_q    <= ar_d;
            arx_q   <= arx_d;
        end
    end

    assign bus.busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.ar_out   = ar_q;
    assign bus.arx_out  = arx_q;
    assign bus.step_amt = (state_q == S_SHIFT) ? pass_amt : 6'd0;

endmodule

// File: tb/tb_shift_seq.sv
// Purpose: self-checking bench for shift_seq against a whole-count reference model.
// Latency: checks pass count, per-pass step_amt and done timing for each request.
// Backpressure: exercises start while busy, start during done, and CROBAR mid-operation.
module tb_shift_seq;

    localparam int W = 36;

    logic clk;
    logic CROBAR;
    int   total;
    int   bad;

    shift_seq_if #(.W(W)) bus ();

    shift_seq #(.W(W), .MAXSTEP(35)) dut (
        .clk    (clk),
        .CROBAR (CROBAR),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: apply the whole count at once. Rotations reduce modulo the
    // rotated width; logical shifts of the full width or more give zero.
    function automatic logic [35:0] rotl36(input logic [35:0] a, input int m);
        int k;
        k = m % 36;
        if (k == 0) return a;
        return (a << k) | (a >> (36 - k));
    endfunction

    function automatic logic [71:0] rotl72(input logic [71:0] a, input int m);
        int k;
        k = m % 72;
        if (k == 0) return a;
        return (a << k) | (a >> (72 - k));
    endfunction

    function automatic logic [71:0] model(input logic [1:0] op, input int n, input bit right,
                                          input logic [35:0] ar, input logic [35:0] arx);
        logic [35:0] a;
        logic [71:0] p;
        p = {ar, arx};
        case (op)
            2'b00: begin
                if (n >= 36) a = '0;
                else a = right ? (ar >> n) : (ar << n);
                return {a, arx};
            end
            2'b01: return {(right ? rotl36(ar, 36 - (n % 36)) : rotl36(ar, n)), arx};
            2'b10: begin
                if (n >= 72) return '0;
                return right ? (p >> n) : (p << n);
            end
            default: return right ? rotl72(p, 72 - (n % 72)) : rotl72(p, n);
        endcase
    endfunction

    // Issue one request from IDLE (entered #1 after a posedge) and follow it.
    task automatic run(input logic [1:0] op, input logic [8:0] cnt,
                       input logic [35:0] ar, input logic [35:0] arx,
                       input int restart_at, input int crobar_at, input bit start_in_done);
        int n, np, rem, a;
        bit right;
        logic [71:0] exp;
        right = cnt[8];
        n     = right ? (512 - int'(cnt)) : int'(cnt);
        np    = (n + 34) / 35;
        exp   = model(op, n, right, ar, arx);

        bus.start  = 1'b1;
        bus.op     = op;
        bus.count  = cnt;
        bus.ar_in  = ar;
        bus.arx_in = arx;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        // scramble inputs: the sequencer must work from its latched copies
        bus.ar_in  = {$urandom, $urandom} & 36'hFFFFFFFFF;
        bus.arx_in = {$urandom, $urandom} & 36'hFFFFFFFFF;
        bus.op     = 2'($urandom);
        bus.count  = 9'($urandom);

        rem = n;
        for (int k = 1; k <= np; k++) begin
            a = (rem > 35) ? 35 : rem;
            rem -= a;
            chk("busy_shift", 72'(bus.busy), 72'd1);
            chk("done_shift", 72'(bus.done), 72'd0);
            chk("step_amt", 72'(bus.step_amt), 72'(a));
            if (k == restart_at) bus.start = 1'b1;
            if (k == crobar_at) begin
                CROBAR = 1'b1;
                @(posedge clk); #1;
                CROBAR = 1'b0;
                chk("abort_busy", 72'(bus.busy), 72'd0);
                chk("abort_done", 72'(bus.done), 72'd0);
                chk("abort_ar", 72'(bus.ar_out), 72'd0);
                chk("abort_arx", 72'(bus.arx_out), 72'd0);
                chk("abort_step", 72'(bus.step_amt), 72'd0);
                for (int j = 0; j < 10; j++) begin
                    @(posedge clk); #1;
                    chk("abort_no_done", 72'(bus.done), 72'd0);
                end
                return;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end

        chk("done_pulse", 72'(bus.done), 72'd1);
        chk("busy_done", 72'(bus.busy), 72'd1);
        chk("step_done", 72'(bus.step_amt), 72'd0);
        chk("ar_result", 72'(bus.ar_out), 72'(exp[71:36]));
        chk("arx_result", 72'(bus.arx_out), 72'(exp[35:0]));
        if (start_in_done) begin
            bus.start = 1'b1;
            bus.count = 9'd5;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("idle_done", 72'(bus.done), 72'd0);
        chk("idle_busy", 72'(bus.busy), 72'd0);
        chk("hold_ar", 72'(bus.ar_out), 72'(exp[71:36]));
        chk("hold_arx", 72'(bus.arx_out), 72'(exp[35:0]));
    endtask

    initial begin
        logic [35:0] r_ar, r_arx;
        total      = 0;
        bad        = 0;
        CROBAR     = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.count  = 9'd0;
        bus.ar_in  = '0;
        bus.arx_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 72'(bus.busy), 72'd0);
        chk("rst_done", 72'(bus.done), 72'd0);
        chk("rst_ar", 72'(bus.ar_out), 72'd0);
        chk("rst_arx", 72'(bus.arx_out), 72'd0);
        chk("rst_step", 72'(bus.step_amt), 72'd0);
        CROBAR = 1'b0;
        @(posedge clk); #1;

        // directed cases
        run(2'b00, 9'd35, 36'o000000000001, 36'o777000111222, 0, 0, 0);
        run(2'b01, 9'd36, 36'o000000000001, 36'o123123123123, 0, 0, 0);
        run(2'b10, 9'd71, 36'o0, 36'o000000000001, 0, 0, 0);
        run(2'b11, 9'(-72), 36'o123456701234, 36'o765432107654, 0, 0, 0);
        run(2'b00, 9'(-256), 36'o400000000000, 36'o555555555555, 0, 0, 0);
        run(2'b11, 9'd255, 36'o123456701234, 36'o765432107654, 0, 0, 0);
        run(2'b01, 9'(-37), 36'o700000000003, 36'o0, 0, 0, 1);
        for (int o = 0; o < 4; o++) begin
            r_ar  = {$urandom, $urandom} & 36'hFFFFFFFFF;
            r_arx = {$urandom, $urandom} & 36'hFFFFFFFFF;
            run(2'(o), 9'd0, r_ar, r_arx, 0, 0, 0);
        end

        // start while busy is ignored; CROBAR mid-operation aborts
        run(2'b10, 9'd200, 36'o123456701234, 36'o765432107654, 2, 0, 0);
        run(2'b10, 9'd200, 36'o123456701234, 36'o765432107654, 0, 3, 0);

        // randomized requests
        for (int i = 0; i < 24; i++) begin
            r_ar  = {$urandom, $urandom} & 36'hFFFFFFFFF;
            r_arx = {$urandom, $urandom} & 36'hFFFFFFFFF;
            run(2'($urandom), 9'($urandom), r_ar, r_arx,
                int'($urandom_range(0, 3)), 0, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle sequencer for the EBOX shift instructions LSH, ROT, LSHC and ROTC.
- The SHM funnel shifter only handles counts 0..35 in one pass; counts of 36 or more are inhibited. This block splits any count in -256..+255 into passes of at most 35 bits.
- It holds the AR/ARX working pair across passes and hands back the final pair with a done pulse.
- It sits beside SHM in the EBOX and is started by the microcode-level shift dispatch.

Parameters:
- W, 36: word width of AR and ARX.
- MAXSTEP, 35: maximum shift amount per pass. Must be in 1..W-1.

Ports:
- clk  in  1: EBOX clock.
- CROBAR  in  1: synchronous, active-high reset.
- start  in  1: request. Sampled only in IDLE.
- op  in  2: operation. 00 LSH (AR only, zero fill), 01 ROT (AR rotate), 10 LSHC (72-bit {AR,ARX} zero fill), 11 ROTC (72-bit rotate).
- count  in  9: signed two's-complement count. Positive shifts left, negative shifts right.
- ar_in  in  W: initial AR. Bit 0 is the MSB (PDP-10 numbering).
- arx_in  in  W: initial ARX.
- busy  out  1: high in SHIFT and DONE.
- done  out  1: one-cycle pulse; results valid during it.
- ar_out  out  W: working AR register.
- arx_out  out  W: working ARX register.
- step_amt  out  6: amount applied in the current SHIFT cycle. 0 outside SHIFT.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, ar_out=0, arx_out=0, step_amt=0, remaining=0.
- CROBAR mid-operation aborts the operation immediately, with the same values as reset. There is no done pulse.
- IDLE + start:
  - Latch op and dir = count[8].
  - remaining = |count|, range 0..256 (10-bit internal).
  - ar_out<=ar_in, arx_out<=arx_in.
  - Next state is SHIFT if remaining != 0, else DONE.
- SHIFT, one pass per clk:
  - amt = min(remaining, MAXSTEP); remaining -= amt.
  - LSH/ROT: AR shifted or rotated by amt in dir. ARX unchanged.
  - LSHC/ROTC: the 72-bit {AR,ARX} is shifted or rotated by amt. AR bit 35 is adjacent to ARX bit 0.
  - When remaining reaches 0 after this pass, next state is DONE.
- Pass count: N = ceil(|count|/MAXSTEP), maximum 8 for |count|=256.
  - Start sampled at edge T.
  - SHIFT occupies cycles T+1..T+N.
  - done=1 during cycle T+N+1, then IDLE.
- count=0: no passes. done is high in the cycle after start, and the outputs equal the inputs.
- count=-256 must give magnitude 256 with no overflow; the internal magnitude is 10 bits.
- Rotates are not reduced modulo W or 2W. Multi-pass composition gives the correct result.
  - Example: ROT by 36 takes 2 passes and returns the original value.
- start while busy is ignored; it is neither queued nor acknowledged.
- start in the DONE cycle is also ignored. A new start is accepted only in IDLE.
- ar_out/arx_out hold their value in IDLE until the next accepted start.
- op values are decoded fully; there are no illegal encodings.

Test Plan:
- LSH, ar_in=000000000001 (octal), count=+35 -> 1 pass, step_amt=35; done at T+2 with ar_out=400000000000.
- ROT, ar_in=000000000001, count=+36 -> 2 passes (35,1); done at T+3 with ar_out=000000000001, arx_out=arx_in unchanged.
- LSHC, ar_in=0, arx_in=000000000001, count=+71 -> 3 passes (35,35,1); ar_out=400000000000, arx_out=0.
- ROTC, ar_in=123456701234, arx_in=765432107654, count=-72 -> 3 passes; outputs equal inputs.
- LSH, ar_in=400000000000, count=-256 -> 8 passes (7x35,11); ar_out=0. count=0 on any op -> done at T+1, outputs equal inputs.
- Mid-operation checks:
  - Start LSHC with count=+200.
  - Assert start again at pass 2 -> ignored; the result is unaffected.
  - In a separate run, CROBAR at pass 3 -> next cycle busy=0, ar_out=arx_out=0, and no done pulse.
